ifu_fetch: RTL and testbench

//  Instruction fetch stage upstream of the single-cycle npc core. Takes a fetch PC, issues one

---
 rtl/ifu_fetch.sv | 121 ++++++++++++
 tb/tb_ifu_fetch.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one memory request/response in flight, result held until the core takes it.
// Optional macro IFU_ALIGN_CHECK_EN faults misaligned fetch PCs without issuing a memory request.
module ifu_fetch #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [31:0] NOP_INST    = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_pc,
  input  logic        flush,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        mem_resp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [1:0]  inst_fault
);

  localparam int unsigned CW      = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned TO_LAST = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q, inst_q;
  logic [1:0]      fault_q;
  logic [CW-1:0]   cnt_q;
  logic [31:0]     cnt_ext;
  logic            timeout_hit;
  logic            accept_ok;
  logic            accept;
  logic            misaligned;

`ifdef IFU_ALIGN_CHECK_EN
  assign misaligned = (fetch_pc[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign cnt_ext     = {{(32-CW){1'b0}}, cnt_q};
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_ext >= TO_LAST);
  assign accept_ok   = !flush && ((state_q == S_IDLE) || ((state_q == S_HOLD) && inst_ready));
  assign accept      = accept_ok && fetch_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = misaligned ? S_HOLD : S_REQ;
      S_REQ: begin
        if (flush)              state_d = S_IDLE;
        else if (mem_req_ready) state_d = S_WAIT;
      end
      // A flush that coincides with the response or the timeout has nothing left to drain.
      S_WAIT: begin
        if (flush)                              state_d = (mem_resp_valid || timeout_hit) ? S_IDLE : S_DRAIN;
        else if (mem_resp_valid || timeout_hit) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (flush)           state_d = S_IDLE;
        else if (accept)     state_d = misaligned ? S_HOLD : S_REQ;
        else if (inst_ready) state_d = S_IDLE;
      end
      S_DRAIN: if (mem_resp_valid || timeout_hit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fetch_ready   = accept_ok && !rst;
    mem_req_valid = (state_q == S_REQ) && !flush;
    inst_valid    = (state_q == S_HOLD) && !flush;
  end

  assign mem_addr   = pc_q;
  assign inst       = inst_q;
  assign inst_pc    = pc_q;
  assign inst_fault = fault_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      inst_q  <= '0;
      fault_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (accept) begin
        pc_q <= fetch_pc;
        if (misaligned) begin
          inst_q  <= NOP_INST;
          fault_q <= 2'b11;
        end
      end
      if (state_q == S_WAIT && !flush) begin
        if (mem_resp_valid) begin
          inst_q  <= mem_resp_err ? NOP_INST : mem_resp_data;
          fault_q <= mem_resp_err ? 2'b01 : 2'b00;
        end else if (timeout_hit) begin
          inst_q  <= NOP_INST;
          fault_q <= 2'b10;
        end
      end
      if (state_q == S_REQ && mem_req_ready && !flush)
        cnt_q <= '0;
      else if ((state_q == S_WAIT || state_q == S_DRAIN) && cnt_q != '1)
        cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed self-checking bench for ifu_fetch (TIMEOUT_CYC overridden to 4).
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid, fetch_ready;
  logic [31:0] fetch_pc;
  logic        flush;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        mem_resp_err;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic [1:0]  inst_fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ifu_fetch #(.TIMEOUT_CYC(4), .NOP_INST(32'h00000013)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
    .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_err(mem_resp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .inst_fault(inst_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, ".fetch_ready"}, 32'(fetch_ready), 32'd0);
    chk({tag, ".mem_req_valid"}, 32'(mem_req_valid), 32'd0);
    chk({tag, ".mem_addr"}, mem_addr, 32'd0);
    chk({tag, ".inst_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, ".inst"}, inst, 32'd0);
    chk({tag, ".inst_pc"}, inst_pc, 32'd0);
    chk({tag, ".inst_fault"}, 32'(inst_fault), 32'd0);
  endtask

  initial begin
    rst = 1'b1; fetch_valid = 1'b0; fetch_pc = '0; flush = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0; mem_resp_err = 1'b0;
    inst_ready = 1'b0;
    #3;
    all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("idle_fetch_ready", 32'(fetch_ready), 32'd1);

    // basic fetch, 3 cycles accept to inst_valid
    fetch_valid = 1'b1; fetch_pc = 32'h80000000;
    #1 chk("t1_accept", 32'(fetch_ready), 32'd1);
    tick();
    fetch_valid = 1'b0; mem_req_ready = 1'b1;
    #1 chk("t1_req_valid", 32'(mem_req_valid), 32'd1);
    chk("t1_addr", mem_addr, 32'h80000000);
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h00100073;
    #1 chk("t1_wait_novalid", 32'(inst_valid), 32'd0);
    chk("t1_wait_noreq", 32'(mem_req_valid), 32'd0);
    tick();
    mem_resp_valid = 1'b0;
    #1 chk("t1_inst_valid", 32'(inst_valid), 32'd1);
    chk("t1_inst", inst, 32'h00100073);
    chk("t1_inst_pc", inst_pc, 32'h80000000);
    chk("t1_fault", 32'(inst_fault), 32'd0);

    // back-to-back fetch from HOLD
    inst_ready = 1'b1; fetch_valid = 1'b1; fetch_pc = 32'h80000004;
    #1 chk("t2_fetch_ready", 32'(fetch_ready), 32'd1);
    tick();
    inst_ready = 1'b0; fetch_valid = 1'b0;
    #1 chk("t2_req_valid", 32'(mem_req_valid), 32'd1);
    chk("t2_addr", mem_addr, 32'h80000004);
    chk("t2_inst_valid", 32'(inst_valid), 32'd0);

    // bus error, held 5 cycles
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_err = 1'b1; mem_resp_data = 32'hdeadbeef;
    tick();
    mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 chk("t3_valid", 32'(inst_valid), 32'd1);
      chk("t3_inst", inst, 32'h00000013);
      chk("t3_fault", 32'(inst_fault), 32'd1);
      chk("t3_pc", inst_pc, 32'h80000004);
      tick();
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    #1 chk("t3_idle_valid", 32'(inst_valid), 32'd0);
    chk("t3_idle_ready", 32'(fetch_ready), 32'd1);

    // timeout after 4 WAIT cycles, late response ignored
    fetch_valid = 1'b1; fetch_pc = 32'h80000008;
    tick();
    fetch_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("t4_wait", 32'(inst_valid), 32'd0);
      tick();
    end
    chk("t4_valid", 32'(inst_valid), 32'd1);
    chk("t4_fault", 32'(inst_fault), 32'd2);
    chk("t4_inst", inst, 32'h00000013);
    chk("t4_pc", inst_pc, 32'h80000008);
    mem_resp_valid = 1'b1; mem_resp_data = 32'h12345678;
    tick();
    mem_resp_valid = 1'b0;
    #1 chk("t4_late_inst", inst, 32'h00000013);
    chk("t4_late_fault", 32'(inst_fault), 32'd2);
    chk("t4_late_valid", 32'(inst_valid), 32'd1);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;

    // flush in WAIT, response 2 cycles later drained
    fetch_valid = 1'b1; fetch_pc = 32'h8000000c;
    tick();
    fetch_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; flush = 1'b1;
    #1 chk("t5_flush_ready", 32'(fetch_ready), 32'd0);
    tick();
    flush = 1'b0;
    #1 chk("t5_drain_valid", 32'(inst_valid), 32'd0);
    chk("t5_drain_ready", 32'(fetch_ready), 32'd0);
    tick();
    mem_resp_valid = 1'b1; mem_resp_data = 32'hcafef00d;
    #1 chk("t5_resp_valid", 32'(inst_valid), 32'd0);
    tick();
    mem_resp_valid = 1'b0;
    #1 chk("t5_idle_ready", 32'(fetch_ready), 32'd1);
    chk("t5_idle_valid", 32'(inst_valid), 32'd0);

    // flush in HOLD masks inst_valid combinationally
    fetch_valid = 1'b1; fetch_pc = 32'h80000010;
    tick();
    fetch_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h00000033;
    tick();
    mem_resp_valid = 1'b0;
    #1 chk("hold_valid", 32'(inst_valid), 32'd1);
    flush = 1'b1;
    #1 chk("hold_flush_valid", 32'(inst_valid), 32'd0);
    chk("hold_flush_ready", 32'(fetch_ready), 32'd0);
    tick();
    flush = 1'b0;
    #1 chk("hold_flush_idle", 32'(fetch_ready), 32'd1);
    chk("hold_flush_novalid", 32'(inst_valid), 32'd0);

    // flush in REQ withdraws the request
    fetch_valid = 1'b1; fetch_pc = 32'h80000014;
    tick();
    fetch_valid = 1'b0; flush = 1'b1; mem_req_ready = 1'b1;
    #1 chk("req_flush_withdraw", 32'(mem_req_valid), 32'd0);
    tick();
    flush = 1'b0; mem_req_ready = 1'b0;
    #1 chk("req_flush_idle", 32'(fetch_ready), 32'd1);
    chk("req_flush_noreq", 32'(mem_req_valid), 32'd0);

    // misaligned PC
    fetch_valid = 1'b1; fetch_pc = 32'h80000002;
    tick();
    fetch_valid = 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
    #1 chk("mis_noreq", 32'(mem_req_valid), 32'd0);
    chk("mis_valid", 32'(inst_valid), 32'd1);
    chk("mis_fault", 32'(inst_fault), 32'd3);
    chk("mis_inst", inst, 32'h00000013);
    chk("mis_pc", inst_pc, 32'h80000002);
`else
    #1 chk("mis_req", 32'(mem_req_valid), 32'd1);
    chk("mis_addr", mem_addr, 32'h80000002);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h00000093;
    tick();
    mem_resp_valid = 1'b0;
    #1 chk("mis_valid", 32'(inst_valid), 32'd1);
    chk("mis_fault", 32'(inst_fault), 32'd0);
    chk("mis_inst", inst, 32'h00000093);
`endif
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;

    // async reset in WAIT
    fetch_valid = 1'b1; fetch_pc = 32'h80000020;
    tick();
    fetch_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    #2 rst = 1'b1;
    #1 all_zero("async_rst");
    tick();
    rst = 1'b0;
    #1 chk("post_rst_ready", 32'(fetch_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
